pipe_ctrl: RTL

Pipeline sequencing controller for the 5-stage core. It combines the load-use stall from the hazard detection unit, EX-stage branch/jump redirects and the instruction/data memory ready handshakes. From these it drives the per-stage register enables and flushes and the PC select. It owns the only sequential state in stall/flush handling: a pending-redirect state used when a redirect arrives while an instruction fetch is still outstanding.

---
 rtl/pipe_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - pipeline sequencing controller for the 5-stage core.
//
// Combines the load-use stall from the hazard unit, EX-stage branch/jump
// redirects and the instruction/data memory ready handshakes into per-stage
// register enables, bubble flushes and the PC select. A redirect that arrives
// while an instruction fetch is still outstanding is parked in TgtReg
// (REDIR_PEND) until the fetch completes.
//
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN
//   defined     : StallCnt / FlushCnt performance counters are implemented
//   not defined : StallCnt / FlushCnt are tied to zero (ports remain)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   HduStall          load-use stall request (ID stage)
//   EX_Redirect       taken branch/jump resolved in EX
//   EX_Target         redirect target from EX
//   IMemReady         instruction fetch completes this cycle
//   DMemReq/DMemReady MEM-stage data access request / completion
//   PC_En, PcSel      PC load enable, PC source (0 = sequential, 1 = PcTarget)
//   PcTarget          redirect address to load into the PC
//   IF_ID_En, ID_EX_En, EX_MEM_En           pipeline register enables
//   IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  load a bubble into that register
//   StallCnt, FlushCnt                      performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HduStall,
  input  logic             EX_Redirect,
  input  logic [XLEN-1:0]  EX_Target,
  input  logic             IMemReady,
  input  logic             DMemReq,
  input  logic             DMemReady,
  output logic             PC_En,
  output logic             PcSel,
  output logic [XLEN-1:0]  PcTarget,
  output logic             IF_ID_En,
  output logic             ID_EX_En,
  output logic             EX_MEM_En,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Flush,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   tgt_reg;
  logic [XLEN-1:0]   tgt_nxt;
  logic              dstall;
  logic              istall;
  // high on the cycles where ID/EX is bubbled because of a redirect
  logic              redir_flush;

  assign dstall = DMemReq & ~DMemReady;
  assign istall = ~IMemReady;

  // Output decode and next-state selection
  always_comb begin
    PC_En        = 1'b1;
    PcSel        = 1'b0;
    PcTarget     = EX_Target;
    IF_ID_En     = 1'b1;
    ID_EX_En     = 1'b1;
    EX_MEM_En    = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    state_nxt    = state;
    tgt_nxt      = tgt_reg;
    redir_flush  = 1'b0;

    if (rst) begin
      PC_En        = 1'b0;
      PcTarget     = '0;
      IF_ID_En     = 1'b0;
      ID_EX_En     = 1'b0;
      EX_MEM_En    = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
      state_nxt    = RUN;
      tgt_nxt      = '0;
    end else begin
      case (state)
        RUN: begin
          if (dstall) begin
            // EX is frozen, so a pending redirect simply re-asserts later
            PC_En        = 1'b0;
            IF_ID_En     = 1'b0;
            ID_EX_En     = 1'b0;
            EX_MEM_En    = 1'b0;
            MEM_WB_Flush = 1'b1;
          end else if (EX_Redirect && IMemReady) begin
            PcSel       = 1'b1;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            redir_flush = 1'b1;
          end else if (EX_Redirect) begin
            // fetch still outstanding: park the target until it completes
            tgt_nxt     = EX_Target;
            state_nxt   = REDIR_PEND;
            PC_En       = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            redir_flush = 1'b1;
          end else if (HduStall) begin
            // load-use wins over istall: IF/ID must hold, not be bubbled
            PC_En       = 1'b0;
            IF_ID_En    = 1'b0;
            ID_EX_Flush = 1'b1;
          end else if (istall) begin
            PC_En       = 1'b0;
            IF_ID_Flush = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end

        REDIR_PEND: begin
          PcTarget    = tgt_reg;
          // the outstanding fetch is wrong-path and must never reach ID
          IF_ID_Flush = 1'b1;
          if (dstall) begin
            ID_EX_En     = 1'b0;
            EX_MEM_En    = 1'b0;
            MEM_WB_Flush = 1'b1;
          end else begin
            MEM_WB_Flush = 1'b0;
          end
          if (EX_Redirect && !dstall) begin
            // newest redirect replaces the parked one; keep waiting
            tgt_nxt = EX_Target;
            PC_En   = 1'b0;
          end else if (istall) begin
            PC_En = 1'b0;
          end else begin
            PcSel     = 1'b1;
            state_nxt = RUN;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State and parked redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      tgt_reg <= '0;
    end else begin
      state   <= state_nxt;
      tgt_reg <= tgt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Performance counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_En) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (redir_flush) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  logic unused_redir_flush;
  assign unused_redir_flush = redir_flush;
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
